// File: rtl/board_shift_merge.sv
// board_shift_merge: sequential 2048 move engine.
// A start request captures the board and direction; one lane is slid and merged
// per clock, then the result, moved flag, score increment and win flag are
// presented together with a single-cycle done pulse.
module board_shift_merge #(
    parameter int TILE_W  = 12,
    parameter int SCORE_W = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [1:0]                       dir,
    input  logic [3:0][3:0][TILE_W-1:0]      board_in,
    output logic [3:0][3:0][TILE_W-1:0]      board_out,
    output logic                             moved,
    output logic [SCORE_W-1:0]               score_add,
    output logic                             win,
    output logic                             busy,
    output logic                             done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_LANE   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    // Largest representable tile; it can never merge because its double does not fit.
    localparam logic [TILE_W-1:0] TILE_MAX = {1'b1, {(TILE_W-1){1'b0}}};

    state_t                          state_reg, state_next;
    logic [1:0]                      lane_reg;
    logic [1:0]                      dir_reg;
    logic [3:0][3:0][TILE_W-1:0]     work_reg;
    logic [3:0][3:0][TILE_W-1:0]     orig_reg;
    logic [3:0][3:0][TILE_W-1:0]     work_next;

    logic [3:0][1:0]                 row_sel;
    logic [3:0][1:0]                 col_sel;
    logic [3:0][TILE_W-1:0]          lane_in;
    logic [3:0][TILE_W-1:0]          packed_t;
    logic [3:0][TILE_W-1:0]          merged_t;
    logic [3:0][TILE_W-1:0]          lane_out;
    logic [SCORE_W-1:0]              lane_score;
    logic                            lane_win;
    logic [2:0]                      fill_idx;
    logic                            skip;

    // Element 0 of a lane is the edge tiles move toward. dir[1] selects a
    // horizontal move (lane = row), dir[0] selects the reversed traversal.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_map
            localparam logic [1:0] FWD = 2'(gi);
            localparam logic [1:0] REV = 2'(3 - gi);
            assign row_sel[gi] = dir_reg[1] ? lane_reg : (dir_reg[0] ? REV : FWD);
            assign col_sel[gi] = dir_reg[1] ? (dir_reg[0] ? REV : FWD) : lane_reg;
            assign lane_in[gi] = work_reg[row_sel[gi]][col_sel[gi]];
        end
    endgenerate

    // Slide, merge each pair at most once from the leading edge, slide again.
    always_comb begin
        packed_t   = '0;
        merged_t   = '0;
        lane_out   = '0;
        lane_score = '0;
        lane_win   = 1'b0;
        skip       = 1'b0;
        fill_idx   = '0;
        for (int e = 0; e < 4; e++) begin
            if (lane_in[e] != '0) begin
                packed_t[fill_idx[1:0]] = lane_in[e];
                fill_idx = fill_idx + 3'd1;
            end
        end
        merged_t = packed_t;
        for (int j = 0; j < 3; j++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (merged_t[j] != '0 && merged_t[j] == merged_t[j+1] &&
                         merged_t[j] != TILE_MAX) begin
                merged_t[j]   = merged_t[j] << 1;
                merged_t[j+1] = '0;
                lane_score    = lane_score + SCORE_W'(merged_t[j]);
                if (merged_t[j] == TILE_MAX) begin
                    lane_win = 1'b1;
                end
                skip = 1'b1;
            end
        end
        fill_idx = '0;
        for (int e = 0; e < 4; e++) begin
            if (merged_t[e] != '0) begin
                lane_out[fill_idx[1:0]] = merged_t[e];
                fill_idx = fill_idx + 3'd1;
            end
        end
    end

    // Working board with the current lane's result written back in place.
    always_comb begin
        work_next = work_reg;
        for (int e = 0; e < 4; e++) begin
            work_next[row_sel[e]][col_sel[e]] = lane_out[e];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> LOAD -> LANE x4 -> FINISH -> IDLE.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE:   if (start) state_next = S_LOAD;
            S_LOAD:   state_next = S_LANE;
            S_LANE:   if (lane_reg == 2'd3) state_next = S_FINISH;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (state_reg == S_LOAD) || (state_reg == S_LANE);
        done = (state_reg == S_FINISH);
    end

    // Datapath: capture, per-lane update, and result publication on the last lane
    // so the result is already valid during the done cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lane_reg  <= '0;
            dir_reg   <= '0;
            work_reg  <= '0;
            orig_reg  <= '0;
            board_out <= '0;
            moved     <= 1'b0;
            score_add <= '0;
            win       <= 1'b0;
        end else begin
            unique case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        work_reg  <= board_in;
                        orig_reg  <= board_in;
                        dir_reg   <= dir;
                        score_add <= '0;
                        win       <= 1'b0;
                        moved     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    lane_reg <= '0;
                end
                S_LANE: begin
                    work_reg  <= work_next;
                    lane_reg  <= lane_reg + 2'd1;
                    score_add <= score_add + lane_score;
                    win       <= win | lane_win;
                    if (lane_reg == 2'd3) begin
                        board_out <= work_next;
                        moved     <= (work_next != orig_reg);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_shift_merge.sv
// Directed bench for board_shift_merge: hand-computed boards, scores and flags.
module tb_board_shift_merge;

    logic                        clk;
    logic                        rst;
    logic                        start;
    logic [1:0]                  dir;
    logic [3:0][3:0][11:0]       board_in;
    logic [3:0][3:0][11:0]       board_out;
    logic                        moved;
    logic [15:0]                 score_add;
    logic                        win;
    logic                        busy;
    logic                        done;

    int checks = 0;
    int errors = 0;

    board_shift_merge #(.TILE_W(12), .SCORE_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dir       (dir),
        .board_in  (board_in),
        .board_out (board_out),
        .moved     (moved),
        .score_add (score_add),
        .win       (win),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row with col0 = a ... col3 = d.
    function automatic logic [47:0] row4(input int a, input int b, input int c, input int d);
        return {12'(d), 12'(c), 12'(b), 12'(a)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue a move and wait (bounded) for done; optionally poke a second start while busy.
    task automatic run_move(input logic [1:0] d, input bit inject);
        int  n;
        bit  got;
        @(negedge clk);
        dir   = d;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (inject && n == 1) begin
                check("busy_at_inject", 64'(busy), 64'd1);
                board_in    = '0;
                board_in[0] = row4(8, 8, 0, 0);
                dir         = ~d;
                start       = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) got = 1'b1;
        end
        check("done_seen", 64'(got), 64'd1);
        check("done_latency", 64'(n), 64'd5);
        @(negedge clk);
        check("done_width", 64'(done), 64'd0);
    endtask

    initial begin
        bit done_seen;
        rst      = 1'b0;
        start    = 1'b0;
        dir      = 2'd0;
        board_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Reset state
        check("rst_board", 64'(board_out != '0), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_score", 64'(score_add), 64'd0);
        $display("reset: busy=%0d done=%0d score=%0d", busy, done, score_add);

        // Left move
        board_in    = '0;
        board_in[0] = row4(2, 2, 2, 2);
        board_in[1] = row4(0, 4, 0, 4);
        board_in[2] = row4(8, 0, 0, 0);
        board_in[3] = row4(2, 4, 8, 16);
        run_move(2'd2, 1'b0);
        check("left_row0", 64'(board_out[0]), 64'(row4(4, 4, 0, 0)));
        check("left_row1", 64'(board_out[1]), 64'(row4(8, 0, 0, 0)));
        check("left_row2", 64'(board_out[2]), 64'(row4(8, 0, 0, 0)));
        check("left_row3", 64'(board_out[3]), 64'(row4(2, 4, 8, 16)));
        check("left_score", 64'(score_add), 64'd16);
        check("left_moved", 64'(moved), 64'd1);
        check("left_win", 64'(win), 64'd0);
        $display("left: score=%0d moved=%0d win=%0d", score_add, moved, win);

        // Reset mid-LANE aborts the move
        @(negedge clk);
        dir   = 2'd2;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("midrst_board", 64'(board_out != '0), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_moved", 64'(moved), 64'd0);
        check("midrst_score", 64'(score_add), 64'd0);
        check("midrst_win", 64'(win), 64'd0);
        done_seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check("midrst_no_done", 64'(done_seen), 64'd0);
        $display("mid-lane reset: busy=%0d done_seen=%0d", busy, done_seen);

        // Up
        board_in    = '0;
        board_in[0] = row4(2, 0, 0, 0);
        board_in[3] = row4(2, 0, 0, 0);
        run_move(2'd0, 1'b0);
        check("up_row0", 64'(board_out[0]), 64'(row4(4, 0, 0, 0)));
        check("up_row3", 64'(board_out[3]), 64'(row4(0, 0, 0, 0)));
        check("up_score", 64'(score_add), 64'd4);
        $display("up: score=%0d moved=%0d", score_add, moved);

        // Down
        run_move(2'd1, 1'b0);
        check("down_row0", 64'(board_out[0]), 64'(row4(0, 0, 0, 0)));
        check("down_row3", 64'(board_out[3]), 64'(row4(4, 0, 0, 0)));
        check("down_score", 64'(score_add), 64'd4);
        $display("down: score=%0d moved=%0d", score_add, moved);

        // No-op left move
        board_in    = '0;
        board_in[0] = row4(2, 4, 0, 0);
        board_in[1] = row4(8, 0, 0, 0);
        board_in[2] = row4(4, 2, 8, 0);
        run_move(2'd2, 1'b0);
        check("noop_moved", 64'(moved), 64'd0);
        check("noop_score", 64'(score_add), 64'd0);
        check("noop_win", 64'(win), 64'd0);
        check("noop_row2", 64'(board_out[2]), 64'(row4(4, 2, 8, 0)));
        $display("noop: score=%0d moved=%0d", score_add, moved);

        // Win
        board_in    = '0;
        board_in[0] = row4(1024, 1024, 0, 0);
        run_move(2'd2, 1'b0);
        check("win_row0", 64'(board_out[0]), 64'(row4(2048, 0, 0, 0)));
        check("win_flag", 64'(win), 64'd1);
        check("win_score", 64'(score_add), 64'd2048);
        $display("win: score=%0d win=%0d", score_add, win);

        // Saturation: 2048 tiles never merge
        board_in    = '0;
        board_in[0] = row4(2048, 2048, 0, 0);
        run_move(2'd3, 1'b0);
        check("sat_row0", 64'(board_out[0]), 64'(row4(0, 0, 2048, 2048)));
        check("sat_moved", 64'(moved), 64'd1);
        check("sat_score", 64'(score_add), 64'd0);
        check("sat_win", 64'(win), 64'd0);
        $display("saturate: score=%0d moved=%0d win=%0d", score_add, moved, win);

        // Start while busy is ignored; result belongs to the first board
        board_in    = '0;
        board_in[0] = row4(2, 2, 0, 0);
        run_move(2'd2, 1'b1);
        check("hs_row0", 64'(board_out[0]), 64'(row4(4, 0, 0, 0)));
        check("hs_score", 64'(score_add), 64'd4);
        $display("handshake: score=%0d row0=%0h", score_add, board_out[0]);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hs_stable_row0", 64'(board_out[0]), 64'(row4(4, 0, 0, 0)));
        end
        check("hs_stable_done", 64'(done), 64'd0);

        // Right move with a triple
        board_in    = '0;
        board_in[0] = row4(2, 2, 2, 0);
        run_move(2'd3, 1'b0);
        check("right_row0", 64'(board_out[0]), 64'(row4(0, 0, 2, 4)));
        check("right_score", 64'(score_add), 64'd4);
        check("right_moved", 64'(moved), 64'd1);
        $display("right: score=%0d row0=%0h", score_add, board_out[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
